sample_stream_ctrl: RTL and testbench

- Sequences periodic sample capture and streams the samples to the DMA as fixed-length AXI-Stream packets.
- Internally generates a one-cycle sample strobe from a programmable divider. It latches the input sample word on each strobe and holds it in a one-entry output register.
- Asserts TLAST on every Nth-sample packet boundary and counts overruns when the DMA backpressures.
- Sits between the PS-configured control registers and the AXI-Stream slave port of the DMA engine.

---
 rtl/sample_stream_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_sample_stream_ctrl.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sample_stream_ctrl.sv
// Periodic sample capture sequencer: divides ACLK into a sample strobe, latches
// each sample into a one-entry AXI-Stream register and frames fixed-length packets.
module sample_stream_ctrl #(
  parameter int C_M_AXIS_DATA_WIDTH = 32,
  parameter int C_LEN_WIDTH         = 16
) (
  input  logic                           ACLK,
  input  logic                           ARESET,
  input  logic [31:0]                    clk_divider,
  input  logic [C_LEN_WIDTH-1:0]         pkt_len,
  input  logic [C_LEN_WIDTH-1:0]         pkt_count,
  input  logic                           start,
  input  logic                           stop,
  input  logic [C_M_AXIS_DATA_WIDTH-1:0] sample_data,
  output logic                           sample_stb,
  output logic [C_M_AXIS_DATA_WIDTH-1:0] M_AXIS_TDATA,
  output logic                           M_AXIS_TVALID,
  input  logic                           M_AXIS_TREADY,
  output logic                           M_AXIS_TLAST,
  output logic                           busy,
  output logic                           done,
  output logic                           cfg_err,
  output logic [15:0]                    overrun_cnt
);

  localparam logic [C_LEN_WIDTH-1:0] C_LEN_ONE = C_LEN_WIDTH'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN
  } state_t;

  state_t r_state;
  state_t w_nextState;

  logic [31:0]                    r_div;
  logic [31:0]                    r_divCnt;
  logic [C_LEN_WIDTH-1:0]         r_len;
  logic [C_LEN_WIDTH-1:0]         r_pktLimit;
  logic [C_LEN_WIDTH-1:0]         r_sampIdx;
  logic [C_LEN_WIDTH-1:0]         r_pktCnt;
  logic                           r_stopPend;
  logic [C_M_AXIS_DATA_WIDTH-1:0] r_tdata;
  logic                           r_tvalid;
  logic                           r_tlast;
  logic                           r_cfgErr;
  logic [15:0]                    r_overrun;
  logic                           r_done;

  logic                   w_run;
  logic                   w_divWrap;
  logic                   w_stb;
  logic                   w_accept;
  logic                   w_load;
  logic                   w_drop;
  logic                   w_lastLoad;
  logic [C_LEN_WIDTH-1:0] w_pktNext;
  logic                   w_pktLimitHit;
  logic                   w_stopReq;
  logic                   w_cfgOk;
  logic                   w_idleStart;
  logic                   w_drainDone;

  assign w_run         = (r_state == S_RUN);
  assign w_divWrap     = (r_divCnt == (r_div - 32'd1));
  assign w_stb         = w_run && w_divWrap;
  assign w_accept      = r_tvalid && M_AXIS_TREADY;
  // A strobe may load while the current beat is being accepted, so no bubble.
  assign w_load        = w_stb && (!r_tvalid || M_AXIS_TREADY);
  assign w_drop        = w_stb && r_tvalid && !M_AXIS_TREADY;
  assign w_lastLoad    = w_load && (r_sampIdx == (r_len - C_LEN_ONE));
  assign w_pktNext     = r_pktCnt + C_LEN_ONE;
  assign w_pktLimitHit = (r_pktLimit != '0) && (w_pktNext == r_pktLimit);
  assign w_stopReq     = r_stopPend || stop;
  assign w_cfgOk       = (clk_divider >= 32'd2) && (pkt_len != '0);
  assign w_idleStart   = (r_state == S_IDLE) && start;

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    w_drainDone = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_idleStart && w_cfgOk) begin
          w_nextState = S_RUN;
        end
      end
      S_RUN: begin
        // Stop only ever takes effect on a packet boundary.
        if (w_lastLoad && (w_stopReq || w_pktLimitHit)) begin
          w_nextState = S_DRAIN;
        end else if (w_stopReq && (r_sampIdx == '0) && !w_load) begin
          w_nextState = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (!r_tvalid || M_AXIS_TREADY) begin
          w_nextState = S_IDLE;
          w_drainDone = 1'b1;
        end
      end
      default: begin
        w_nextState = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_div      <= '0;
      r_divCnt   <= '0;
      r_len      <= '0;
      r_pktLimit <= '0;
      r_sampIdx  <= '0;
      r_pktCnt   <= '0;
      r_stopPend <= 1'b0;
      r_tdata    <= '0;
      r_tvalid   <= 1'b0;
      r_tlast    <= 1'b0;
      r_cfgErr   <= 1'b0;
      r_overrun  <= '0;
      r_done     <= 1'b0;
    end else begin
      r_done <= w_drainDone;

      if (w_idleStart) begin
        r_cfgErr <= !w_cfgOk;
        if (w_cfgOk) begin
          r_div      <= clk_divider;
          r_len      <= pkt_len;
          r_pktLimit <= pkt_count;
          r_divCnt   <= '0;
          r_sampIdx  <= '0;
          r_pktCnt   <= '0;
          r_stopPend <= 1'b0;
          r_overrun  <= '0;
        end
      end

      if (w_run) begin
        r_divCnt <= w_divWrap ? 32'd0 : (r_divCnt + 32'd1);
        if (stop) begin
          r_stopPend <= 1'b1;
        end
      end

      if (w_load) begin
        r_tdata  <= sample_data;
        r_tlast  <= w_lastLoad;
        r_tvalid <= 1'b1;
        if (w_lastLoad) begin
          r_sampIdx <= '0;
          r_pktCnt  <= w_pktNext;
        end else begin
          r_sampIdx <= r_sampIdx + C_LEN_ONE;
        end
      end else if (w_accept) begin
        r_tvalid <= 1'b0;
        r_tlast  <= 1'b0;
      end

      // Dropped samples leave the sample index untouched so packets stay exact.
      if (w_drop && (r_overrun != 16'hFFFF)) begin
        r_overrun <= r_overrun + 16'd1;
      end
    end
  end

  assign sample_stb    = w_stb;
  assign M_AXIS_TDATA  = r_tdata;
  assign M_AXIS_TVALID = r_tvalid;
  assign M_AXIS_TLAST  = r_tlast;
  assign busy          = (r_state != S_IDLE);
  assign done          = r_done;
  assign cfg_err       = r_cfgErr;
  assign overrun_cnt   = r_overrun;

endmodule

// File: tb/tb_sample_stream_ctrl.sv
// Directed bench for sample_stream_ctrl: sample_data tracks the cycle number, so
// each beat's expected payload and cycle are derived from the start cycle.
module tb_sample_stream_ctrl;

  localparam logic [31:0] BASE = 32'hA500_0000;

  logic        ACLK = 1'b0;
  logic        ARESET = 1'b1;
  logic [31:0] clk_divider = '0;
  logic [15:0] pkt_len = '0;
  logic [15:0] pkt_count = '0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic [31:0] sample_data = '0;
  logic        sample_stb;
  logic [31:0] M_AXIS_TDATA;
  logic        M_AXIS_TVALID;
  logic        M_AXIS_TREADY = 1'b1;
  logic        M_AXIS_TLAST;
  logic        busy;
  logic        done;
  logic        cfg_err;
  logic [15:0] overrun_cnt;

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   stallLo = -1;
  int   stallHi = -1;
  logic readyHi = 1'b1;

  logic [31:0] beatData[$];
  logic        beatLast[$];
  int          beatCyc[$];
  int          stbCyc[$];
  int          doneCyc[$];
  int          stallErr = 0;
  logic        prevStall = 1'b0;
  logic [31:0] prevData = '0;
  logic        prevLast = 1'b0;

  sample_stream_ctrl #(
    .C_M_AXIS_DATA_WIDTH(32),
    .C_LEN_WIDTH(16)
  ) dut (
    .ACLK(ACLK),
    .ARESET(ARESET),
    .clk_divider(clk_divider),
    .pkt_len(pkt_len),
    .pkt_count(pkt_count),
    .start(start),
    .stop(stop),
    .sample_data(sample_data),
    .sample_stb(sample_stb),
    .M_AXIS_TDATA(M_AXIS_TDATA),
    .M_AXIS_TVALID(M_AXIS_TVALID),
    .M_AXIS_TREADY(M_AXIS_TREADY),
    .M_AXIS_TLAST(M_AXIS_TLAST),
    .busy(busy),
    .done(done),
    .cfg_err(cfg_err),
    .overrun_cnt(overrun_cnt)
  );

  always #5 ACLK = ~ACLK;

  // Mid-cycle observer: a beat seen valid&&ready here is accepted at the next edge.
  always @(negedge ACLK) begin
    if (ARESET) begin
      prevStall <= 1'b0;
    end else begin
      if (prevStall && (!M_AXIS_TVALID || (M_AXIS_TDATA !== prevData) || (M_AXIS_TLAST !== prevLast))) begin
        stallErr <= stallErr + 1;
      end
      prevStall <= M_AXIS_TVALID && !M_AXIS_TREADY;
      prevData  <= M_AXIS_TDATA;
      prevLast  <= M_AXIS_TLAST;
      if (M_AXIS_TVALID && M_AXIS_TREADY) begin
        beatData.push_back(M_AXIS_TDATA);
        beatLast.push_back(M_AXIS_TLAST);
        beatCyc.push_back(cyc);
      end
      if (sample_stb) stbCyc.push_back(cyc);
      if (done) doneCyc.push_back(cyc);
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(posedge ACLK);
    #1;
    cyc++;
    sample_data = BASE + 32'(cyc);
    M_AXIS_TREADY = (cyc >= stallLo && cyc <= stallHi) ? 1'b0 : readyHi;
  endtask

  task automatic runTo(input int target);
    while (cyc < target) step();
  endtask

  task automatic applyStimulus(input logic [31:0] d, input logic [15:0] l, input logic [15:0] n, output int a);
    clk_divider = d;
    pkt_len = l;
    pkt_count = n;
    start = 1'b1;
    a = cyc;
    step();
    start = 1'b0;
  endtask

  task automatic waitDone(input string tag, input int d0, input int budget);
    int k = 0;
    while (doneCyc.size() == d0 && k < budget) begin
      step();
      k++;
    end
    checkOutput({tag, " done seen"}, 32'(doneCyc.size() - d0), 32'd1);
  endtask

  task automatic checkBeat(input string tag, input int b0, input int idx, input logic [31:0] expData,
                           input logic expLast, input int expCyc);
    logic [31:0] od, oc;
    logic        ol;
    if (b0 + idx < beatData.size()) begin
      od = beatData[b0 + idx];
      ol = beatLast[b0 + idx];
      oc = 32'(beatCyc[b0 + idx]);
    end else begin
      od = 'x;
      ol = 1'bx;
      oc = 'x;
    end
    checkOutput($sformatf("%s beat%0d data", tag, idx + 1), od, expData);
    checkOutput($sformatf("%s beat%0d last", tag, idx + 1), 32'(ol), 32'(expLast));
    checkOutput($sformatf("%s beat%0d cycle", tag, idx + 1), oc, 32'(expCyc));
  endtask

  initial begin
    int a, b0, s0, d0;

    step();
    step();
    step();
    checkOutput("reset tvalid", 32'(M_AXIS_TVALID), 0);
    checkOutput("reset tdata", M_AXIS_TDATA, 0);
    checkOutput("reset stb/busy/done/err", {28'd0, sample_stb, busy, done, cfg_err}, 0);
    checkOutput("reset overrun", 32'(overrun_cnt), 0);
    ARESET = 1'b0;
    step();

    // D=4 L=3 N=2, always ready
    b0 = beatData.size(); s0 = stbCyc.size(); d0 = doneCyc.size();
    applyStimulus(4, 3, 2, a);
    checkOutput("t1 busy", 32'(busy), 1);
    waitDone("t1", d0, 60);
    checkOutput("t1 beats", 32'(beatData.size() - b0), 6);
    for (int j = 1; j <= 6; j++) checkBeat("t1", b0, j - 1, BASE + 32'(a + 4 * j), (j % 3) == 0, a + 4 * j + 1);
    checkOutput("t1 strobes", 32'(stbCyc.size() - s0), 6);
    for (int j = 0; j < 6 && s0 + j < stbCyc.size(); j++)
      checkOutput($sformatf("t1 stb%0d cycle", j + 1), 32'(stbCyc[s0 + j]), 32'(a + 4 * (j + 1)));
    if (doneCyc.size() > d0) checkOutput("t1 done cycle", 32'(doneCyc[d0]), 32'(a + 26));
    checkOutput("t1 overrun", 32'(overrun_cnt), 0);
    step(); step(); step();
    checkOutput("t1 done once", 32'(doneCyc.size() - d0), 1);
    checkOutput("t1 idle", 32'(busy), 0);

    // D=2 L=4 N=1, ready low for 5 cycles once the first beat is up
    b0 = beatData.size(); d0 = doneCyc.size();
    stallLo = cyc + 3; stallHi = cyc + 7;
    applyStimulus(2, 4, 1, a);
    runTo(a + 5);
    checkOutput("t2 held valid", 32'(M_AXIS_TVALID), 1);
    checkOutput("t2 held data", M_AXIS_TDATA, BASE + 32'(a + 2));
    checkOutput("t2 overrun mid", 32'(overrun_cnt), 1);
    waitDone("t2", d0, 60);
    checkOutput("t2 beats", 32'(beatData.size() - b0), 4);
    checkBeat("t2", b0, 0, BASE + 32'(a + 2), 1'b0, a + 8);
    checkBeat("t2", b0, 1, BASE + 32'(a + 8), 1'b0, a + 9);
    checkBeat("t2", b0, 2, BASE + 32'(a + 10), 1'b0, a + 11);
    checkBeat("t2", b0, 3, BASE + 32'(a + 12), 1'b1, a + 13);
    checkOutput("t2 overrun", 32'(overrun_cnt), 2);
    checkOutput("t2 stable under stall", 32'(stallErr), 0);
    if (doneCyc.size() > d0) checkOutput("t2 done cycle", 32'(doneCyc[d0]), 32'(a + 14));
    stallLo = -1; stallHi = -1;
    step();

    // D=3 L=8 N=0, stop after beat 2 finishes the packet
    b0 = beatData.size(); s0 = stbCyc.size(); d0 = doneCyc.size();
    applyStimulus(3, 8, 0, a);
    runTo(a + 8);
    stop = 1'b1;
    step();
    stop = 1'b0;
    checkOutput("t3 busy after stop", 32'(busy), 1);
    waitDone("t3", d0, 80);
    checkOutput("t3 beats", 32'(beatData.size() - b0), 8);
    for (int j = 1; j <= 8; j++) checkBeat("t3", b0, j - 1, BASE + 32'(a + 3 * j), j == 8, a + 3 * j + 1);
    if (doneCyc.size() > d0) checkOutput("t3 done cycle", 32'(doneCyc[d0]), 32'(a + 26));
    for (int k = 0; k < 10; k++) step();
    checkOutput("t3 no more strobes", 32'(stbCyc.size() - s0), 8);
    checkOutput("t3 idle", 32'(busy), 0);

    // stop at sample index 0 before any strobe: immediate drain, no beats
    b0 = beatData.size(); s0 = stbCyc.size(); d0 = doneCyc.size();
    applyStimulus(3, 8, 0, a);
    stop = 1'b1;
    step();
    stop = 1'b0;
    waitDone("t3b", d0, 20);
    if (doneCyc.size() > d0) checkOutput("t3b done cycle", 32'(doneCyc[d0]), 32'(a + 3));
    checkOutput("t3b beats", 32'(beatData.size() - b0), 0);
    checkOutput("t3b strobes", 32'(stbCyc.size() - s0), 0);

    // bad config rejected, good config accepted, start while busy ignored
    applyStimulus(1, 3, 1, a);
    checkOutput("t4 cfg_err", 32'(cfg_err), 1);
    checkOutput("t4 rejected busy", 32'(busy), 0);
    step(); step();
    checkOutput("t4 still idle", 32'(busy), 0);
    b0 = beatData.size(); d0 = doneCyc.size();
    applyStimulus(5, 2, 1, a);
    checkOutput("t4 cfg_err cleared", 32'(cfg_err), 0);
    checkOutput("t4 busy", 32'(busy), 1);
    runTo(a + 7);
    clk_divider = 2; pkt_len = 4; start = 1'b1;
    step();
    start = 1'b0;
    waitDone("t4", d0, 40);
    checkOutput("t4 beats", 32'(beatData.size() - b0), 2);
    checkBeat("t4", b0, 0, BASE + 32'(a + 5), 1'b0, a + 6);
    checkBeat("t4", b0, 1, BASE + 32'(a + 10), 1'b1, a + 11);
    applyStimulus(5, 0, 1, a);
    checkOutput("t4 zero len cfg_err", 32'(cfg_err), 1);
    checkOutput("t4 zero len busy", 32'(busy), 0);

    // reset mid-packet while stalled, then a fresh run
    readyHi = 1'b0;
    step();
    applyStimulus(2, 4, 0, a);
    runTo(a + 6);
    checkOutput("t5 stalled valid", 32'(M_AXIS_TVALID), 1);
    checkOutput("t5 overrun before reset", 32'(overrun_cnt), 1);
    ARESET = 1'b1;
    step();
    checkOutput("t5 reset tvalid", 32'(M_AXIS_TVALID), 0);
    checkOutput("t5 reset busy", 32'(busy), 0);
    checkOutput("t5 reset overrun", 32'(overrun_cnt), 0);
    checkOutput("t5 reset cfg_err", 32'(cfg_err), 0);
    ARESET = 1'b0;
    readyHi = 1'b1;
    step();
    b0 = beatData.size(); d0 = doneCyc.size();
    applyStimulus(4, 3, 1, a);
    waitDone("t5", d0, 40);
    checkOutput("t5 beats", 32'(beatData.size() - b0), 3);
    for (int j = 1; j <= 3; j++) checkBeat("t5", b0, j - 1, BASE + 32'(a + 4 * j), j == 3, a + 4 * j + 1);
    checkOutput("t5 overrun", 32'(overrun_cnt), 0);

    // D=2 back-to-back beats, no drops
    b0 = beatData.size(); d0 = doneCyc.size();
    applyStimulus(2, 4, 2, a);
    waitDone("t6", d0, 60);
    checkOutput("t6 beats", 32'(beatData.size() - b0), 8);
    for (int j = 1; j <= 8; j++) checkBeat("t6", b0, j - 1, BASE + 32'(a + 2 * j), (j % 4) == 0, a + 2 * j + 1);
    checkOutput("t6 overrun", 32'(overrun_cnt), 0);
    if (doneCyc.size() > d0) checkOutput("t6 done cycle", 32'(doneCyc[d0]), 32'(a + 18));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
